// File: rtl/pp_col_streamer.sv
// rtl/pp_col_streamer.sv - partial-product matrix transposer streaming column beats
module pp_col_streamer #(
   parameter int PP_NUM        = 17,
   parameter int PP_WIDTH      = 64,
   parameter int COLS_PER_BEAT = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [PP_NUM*PP_WIDTH-1:0]      in_pp,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [COLS_PER_BEAT*PP_NUM-1:0] out_cols,
   output logic [$clog2(PP_WIDTH)-1:0]     out_col_base,
   output logic                            out_last,
   output logic                            busy
);
   localparam int BEATS  = PP_WIDTH / COLS_PER_BEAT;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int COL_W  = $clog2(PP_WIDTH);
   localparam int SLICE  = COLS_PER_BEAT * PP_NUM;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                     state;
   logic [BEAT_W-1:0]          beat;
   logic [PP_NUM*PP_WIDTH-1:0] pp_buf;
   logic [PP_NUM*PP_WIDTH-1:0] cols_all;
   logic                       accept;
   logic                       xfer;

   // Column-major view of the held matrix: column c lives in cols_all[c*PP_NUM +: PP_NUM].
   for (genvar c = 0; c < PP_WIDTH; c++) begin : g_col
      for (genvar r = 0; r < PP_NUM; r++) begin : g_row
         assign cols_all[c*PP_NUM + r] = pp_buf[r*PP_WIDTH + c];
      end
   end

   assign out_valid    = (state == STREAM);
   assign busy         = (state == STREAM);
   assign out_last     = (beat == LAST_BEAT);
   assign out_cols     = cols_all[beat*SLICE +: SLICE];
   assign out_col_base = COL_W'(beat) * COL_W'(COLS_PER_BEAT);

   assign xfer     = out_valid && out_ready;
   assign in_ready = !flush && ((state == IDLE) || (xfer && out_last));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         beat   <= '0;
         pp_buf <= '0;
      end else if (flush) begin
         state  <= IDLE;
         beat   <= '0;
         pp_buf <= '0;
      end else if (accept) begin
         // Covers both a fresh start from IDLE and the bubble-free last-beat handoff.
         state  <= STREAM;
         beat   <= '0;
         pp_buf <= in_pp;
      end else if (xfer) begin
         if (out_last) begin
            state <= IDLE;
            beat  <= '0;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end
endmodule

// File: doc/pp_col_streamer.md
Name: pp_col_streamer

Overview:
- Buffered, handshaked partial-product transposer for the multi-cycle multiplier datapath.
- Captures PP_NUM partial products of PP_WIDTH bits each, transposes them into per-column bit vectors, and streams the columns to the compression tree COLS_PER_BEAT columns per beat.
- Uses valid/ready on both sides, back-to-back matrix acceptance and a synchronous flush for pipeline cancel.

Parameters:
- PP_NUM, 17, number of partial products (rows).
- PP_WIDTH, 64, bits per partial product (columns).
- COLS_PER_BEAT, 16, columns emitted per output beat. Must divide PP_WIDTH. BEATS = PP_WIDTH/COLS_PER_BEAT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous cancel: drop the held matrix.
- in_valid  in  1  in_pp is valid.
- in_ready  out  1  block accepts in_pp this cycle.
- in_pp  in  PP_NUM*PP_WIDTH  row i = in_pp[i*PP_WIDTH +: PP_WIDTH].
- out_valid  out  1  out_cols is valid.
- out_ready  in  1  consumer accepts the beat.
- out_cols  out  COLS_PER_BEAT*PP_NUM  slot k = out_cols[k*PP_NUM +: PP_NUM]; bit i of slot k = row i, column out_col_base+k.
- out_col_base  out  clog2(PP_WIDTH)  index of the first column in the beat (beat*COLS_PER_BEAT).
- out_last  out  1  current beat is beat BEATS-1.
- busy  out  1  a matrix is held (state STREAM).

Behaviour:
- Async reset: state IDLE, beat counter 0, matrix buffer 0. Outputs: out_valid 0, out_cols 0, out_col_base 0, out_last 0 (BEATS=1 gives 1), busy 0, in_ready 1.
- States: IDLE and STREAM.
- in_ready = !flush & (IDLE | (out_valid & out_ready & out_last)).
- Accept = in_valid & in_ready. On accept: register in_pp into the buffer, set beat counter to 0, next state STREAM.
- In STREAM, out_valid = 1 and out_cols/out_col_base/out_last are driven from the buffer and the beat counter. These are registered-state derived, with no combinational path from in_pp.
- Latency: matrix accepted at edge N, beat 0 valid from edge N onward (visible the cycle after the accept cycle).
- out_valid & out_ready & !out_last: counter +1.
- out_valid & out_ready & out_last, no accept: next state IDLE, counter 0.
- Last-beat handoff with a simultaneous accept: stay in STREAM, load the new matrix, counter 0. No bubble; throughput is one matrix per BEATS cycles.
- Backpressure: while out_valid & !out_ready, out_cols, out_col_base and out_last hold stable, and the buffer does not change.
- flush (priority over everything except reset):
  - next state IDLE, counter 0, held matrix discarded;
  - in_ready is 0 in the flush cycle, so in_pp is not captured even if in_valid=1;
  - out_valid stays as in that cycle, but the beat is not counted as transferred by this block.
- out_valid is never asserted in IDLE.
- The counter never exceeds BEATS-1. out_col_base = counter*COLS_PER_BEAT, zero-extended.
- BEATS=1: every beat has out_last=1, and the block degenerates to a registered full transpose with handshake.
- Stored data is not modified: pure bit permutation, no sign extension or arithmetic.

Test Plan:
- Reset mid-stream: assert reset during beat 2 with out_ready=0 -> out_valid, busy, out_cols and out_col_base are 0 immediately and in_ready=1. After release, no beats are emitted until a new accept.
- Diagonal matrix, row i = 1<<i (i=0..16), out_ready=1:
  - 4 beats with out_col_base 0, 16, 32, 48;
  - beat 0 slot k = 17'h1<<k for k=0..15; beat 1 slot 0 = 17'h10000;
  - all other slots 0; out_last only on the beat with base 48.
- Backpressure: drop out_ready for 3 cycles on beat 2 of an all-ones matrix -> out_col_base=32 and every slot = 17'h1FFFF held for 3 cycles. Beat 3 follows after out_ready rises; total 4 transfers.
- Back-to-back: second matrix (row 0 = 64'hFFFF_FFFF_FFFF_FFFF, others 0) presented during beat 3 of the first -> accepted in the same cycle, next cycle beat 0 with every slot = 17'h00001, no idle cycle between.
- Flush at beat 1 with in_valid=1 -> next cycle out_valid=0 and busy=0, the new matrix is not accepted in the flush cycle, and it is accepted the following cycle.
- COLS_PER_BEAT=64 build: only row 16 all-ones -> single beat, out_last=1, out_col_base=0, all 64 slots = 17'h10000, then IDLE.
